// File: rtl/float_to_int_if.sv
// Handshake bundle for the float to int converter: float operand in, integer plus flags out.
interface float_to_int_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] fl;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_nv;
   logic        out_of;
   logic        out_nx;

   modport slave (
      input  in_valid, fl, out_ready,
      output in_ready, out_valid, out_data, out_nv, out_of, out_nx
   );

   modport master (
      output in_valid, fl, out_ready,
      input  in_ready, out_valid, out_data, out_nv, out_of, out_nx
   );
endinterface

// File: rtl/float_to_int.sv
// IEEE-754 single to signed 32-bit integer converter: capture, classify, align, round/saturate.
// One global stage enable; the whole pipeline freezes under output backpressure.
module float_to_int #(
   parameter int ROUND_NEAREST = 0
) (
   input  logic           clk,
   input  logic           rst,
   float_to_int_if.slave  bus
);

   localparam bit RN = (ROUND_NEAREST != 0);

   logic en;
   assign en           = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = en;

   // capture
   logic        v0;
   logic [31:0] f0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v0 <= 1'b0;
         f0 <= '0;
      end else if (en) begin
         v0 <= bus.in_valid;
         f0 <= bus.fl;
      end
   end

   // classify
   logic [7:0]  e0;
   logic [22:0] m0;
   logic [7:0]  sh_full;
   logic        c_nan, c_inf, c_tiny, c_big, c_min, c_e126, c_nz;

   assign e0      = f0[30:23];
   assign m0      = f0[22:0];
   assign sh_full = e0 - 8'd127;
   assign c_nan   = (e0 == 8'hFF) && (m0 != '0);
   assign c_inf   = (e0 == 8'hFF) && (m0 == '0);
   // Everything below 1.0 takes the tiny path; exp==126 supplies the guard bit there.
   assign c_tiny  = (e0 < 8'd127);
   assign c_big   = (e0 >= 8'd158);
   assign c_min   = (f0 == 32'hCF00_0000);
   assign c_e126  = (e0 == 8'd126);
   assign c_nz    = (f0[30:0] != '0);

   logic        v1, sign1, nan1, sat1, tiny1, min1, e126_1, nz1;
   logic [4:0]  sh1;
   logic [22:0] mnt1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1     <= 1'b0;
         sign1  <= 1'b0;
         nan1   <= 1'b0;
         sat1   <= 1'b0;
         tiny1  <= 1'b0;
         min1   <= 1'b0;
         e126_1 <= 1'b0;
         nz1    <= 1'b0;
         sh1    <= '0;
         mnt1   <= '0;
      end else if (en) begin
         v1     <= v0;
         sign1  <= f0[31];
         nan1   <= c_nan;
         sat1   <= c_inf || c_big;
         tiny1  <= c_tiny;
         min1   <= c_min;
         e126_1 <= c_e126;
         nz1    <= c_nz;
         sh1    <= sh_full[4:0];
         mnt1   <= m0;
      end
   end

   // align: significand value is sig * 2^(sh1-23)
   logic [23:0] sig;
   logic [4:0]  rs_amt, ls_amt;
   logic [47:0] rsh;
   logic [32:0] a_mag;
   logic        a_g, a_st;

   assign sig    = {1'b1, mnt1};
   assign rs_amt = 5'd23 - sh1;
   assign ls_amt = sh1 - 5'd23;

   always_comb begin
      a_mag = '0;
      a_g   = 1'b0;
      a_st  = 1'b0;
      rsh   = '0;
      if (tiny1) begin
         a_g  = e126_1;
         a_st = e126_1 ? (mnt1 != '0) : nz1;
      end else if (sh1 >= 5'd23) begin
         a_mag = {9'b0, sig} << ls_amt;
      end else begin
         rsh   = {sig, 24'b0} >> rs_amt;
         a_mag = {9'b0, rsh[47:24]};
         a_g   = rsh[23];
         a_st  = |rsh[22:0];
      end
   end

   logic        v2, sign2, nan2, sat2, min2, g2, st2;
   logic [32:0] mag2;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v2    <= 1'b0;
         sign2 <= 1'b0;
         nan2  <= 1'b0;
         sat2  <= 1'b0;
         min2  <= 1'b0;
         g2    <= 1'b0;
         st2   <= 1'b0;
         mag2  <= '0;
      end else if (en) begin
         v2    <= v1;
         sign2 <= sign1;
         nan2  <= nan1;
         sat2  <= sat1;
         min2  <= min1;
         g2    <= a_g;
         st2   <= a_st;
         mag2  <= a_mag;
      end
   end

   // round, sign, saturate
   logic        inc, over;
   logic [32:0] mr, neg;
   logic [31:0] r_data;
   logic        r_nv, r_of, r_nx;

   assign inc  = RN && g2 && (st2 || mag2[0]);
   assign mr   = mag2 + {32'b0, inc};
   assign neg  = 33'd0 - mr;
   assign over = sign2 ? (mr > 33'h0_8000_0000) : (mr > 33'h0_7FFF_FFFF);

   always_comb begin
      r_data = '0;
      r_nv   = 1'b0;
      r_of   = 1'b0;
      r_nx   = 1'b0;
      if (nan2) begin
         r_data = 32'h8000_0000;
         r_nv   = 1'b1;
      end else if (min2) begin
         // exactly -2^31 is representable even though its exponent is in the big range
         r_data = 32'h8000_0000;
      end else if (sat2 || over) begin
         r_data = sign2 ? 32'h8000_0000 : 32'h7FFF_FFFF;
         r_of   = 1'b1;
      end else begin
         r_data = sign2 ? neg[31:0] : mr[31:0];
         r_nx   = g2 || st2;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_nv    <= 1'b0;
         bus.out_of    <= 1'b0;
         bus.out_nx    <= 1'b0;
      end else if (en) begin
         bus.out_valid <= v2;
         bus.out_data  <= r_data;
         bus.out_nv    <= r_nv;
         bus.out_of    <= r_of;
         bus.out_nx    <= r_nx;
      end
   end

endmodule
